// File: rtl/multiway_traffic_controller.sv
// ---------------------------------------------------------------------------
// multiway_traffic_controller
//
// Parametrised N-way intersection sequencer. It cycles through the
// approaches (STARTUP -> GREEN -> YELLOW -> ALLRED -> GREEN ...), can skip
// approaches that report no demand, and can hand the intersection to an
// emergency approach (PREEMPT) for as long as the request is held.
// Phase durations are counted in prescaler ticks of TICK_DIV clk cycles.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-low reset
//   demand       per-approach vehicle presence (level)
//   preempt_req  emergency preemption request (level)
//   preempt_dir  approach to serve while preempted
//   lights       3 bits per approach at [3d+2:3d]; red=100 yellow=010 green=001
//   active_dir   approach that is green/yellow or was served last
//   phase        0 STARTUP, 1 GREEN, 2 YELLOW, 3 ALLRED, 4 PREEMPT
//   tick         prescaler pulse
// ---------------------------------------------------------------------------
module multiway_traffic_controller #(
  parameter int NUM_DIR       = 4,
  parameter int TICK_DIV      = 1,
  parameter int CNT_W         = 8,
  parameter int STARTUP_TICKS = 10,
  parameter int GREEN_TICKS   = 30,
  parameter int YELLOW_TICKS  = 5,
  parameter int ALLRED_TICKS  = 2,
  parameter int SKIP_EN       = 1,
  localparam int DW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_DIR-1:0]   demand,
  input  logic                 preempt_req,
  input  logic [DW-1:0]        preempt_dir,
  output logic [3*NUM_DIR-1:0] lights,
  output logic [DW-1:0]        active_dir,
  output logic [2:0]           phase,
  output logic                 tick
);

  typedef enum logic [2:0] {
    PH_STARTUP = 3'd0,
    PH_GREEN   = 3'd1,
    PH_YELLOW  = 3'd2,
    PH_ALLRED  = 3'd3,
    PH_PREEMPT = 3'd4
  } phase_e;

  localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIVW-1:0]      DIV_LAST     = DIVW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]     STARTUP_LAST = CNT_W'(STARTUP_TICKS - 1);
  localparam logic [CNT_W-1:0]     GREEN_LAST   = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0]     YELLOW_LAST  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0]     ALLRED_LAST  = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [3*NUM_DIR-1:0] ALL_RED      = {NUM_DIR{3'b100}};

  logic [DIVW-1:0]      div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  phase_e               phase_q, phase_d;
  logic [DW-1:0]        dir_q, dir_d;
  logic [3*NUM_DIR-1:0] lights_q, lights_d;

  logic          tick_int;
  logic          preempt_ok;
  logic [DW-1:0] next_dir;
  logic [DW-1:0] cand;
  logic          found;
  logic [2:0]    lamp_code;

  assign tick_int = (div_q == DIV_LAST);
  // Gated with rst so tick reads 0 while reset is held, yet is already
  // high in cycle 0 of STARTUP when TICK_DIV=1.
  assign tick     = tick_int & rst;

  // Requests naming a non-existent approach are ignored altogether.
  assign preempt_ok = preempt_req && (int'(preempt_dir) < NUM_DIR);

  // Round-robin search starting after the current approach and ending on
  // the current approach itself; falls back to plain rotation when nobody
  // is waiting or skipping is disabled.
  always_comb begin
    next_dir = DW'((int'(dir_q) + 1) % NUM_DIR);
    cand     = '0;
    found    = 1'b0;
    if (SKIP_EN != 0) begin
      for (int i = 1; i <= NUM_DIR; i++) begin
        cand = DW'((int'(dir_q) + i) % NUM_DIR);
        if (!found && demand[cand]) begin
          found    = 1'b1;
          next_dir = cand;
        end
      end
    end
  end

  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);
    cnt_d   = tick_int ? cnt_q + CNT_W'(1) : cnt_q;
    phase_d = phase_q;
    dir_d   = dir_q;

    case (phase_q)
      PH_STARTUP: begin
        if (tick_int && cnt_q == STARTUP_LAST) begin
          phase_d = PH_GREEN;
          dir_d   = '0;
          cnt_d   = '0;
        end
      end
      PH_GREEN: begin
        // Preemption acts on the next edge, independent of the prescaler.
        if (preempt_ok && preempt_dir == dir_q) begin
          phase_d = PH_PREEMPT;
          cnt_d   = '0;
        end else if (preempt_ok || (tick_int && cnt_q == GREEN_LAST)) begin
          phase_d = PH_YELLOW;
          cnt_d   = '0;
        end
      end
      PH_YELLOW: begin
        if (tick_int && cnt_q == YELLOW_LAST) begin
          phase_d = PH_ALLRED;
          cnt_d   = '0;
        end
      end
      PH_ALLRED: begin
        if (tick_int && cnt_q == ALLRED_LAST) begin
          cnt_d = '0;
          if (preempt_ok) begin
            phase_d = PH_PREEMPT;
            dir_d   = preempt_dir;
          end else begin
            phase_d = PH_GREEN;
            dir_d   = next_dir;
          end
        end
      end
      PH_PREEMPT: begin
        // The served approach was latched on entry, so only the request
        // level matters here.
        if (!preempt_req) begin
          phase_d = PH_YELLOW;
          cnt_d   = '0;
        end
      end
      default: begin
        phase_d = PH_STARTUP;
        dir_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Lamps are derived from the next state so they change on the same
    // edge as the phase, and only one approach can ever be non-red.
    case (phase_d)
      PH_GREEN, PH_PREEMPT: lamp_code = 3'b001;
      PH_YELLOW:            lamp_code = 3'b010;
      default:              lamp_code = 3'b100;
    endcase
    lights_d = ALL_RED;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (DW'(d) == dir_d) lights_d[3*d +: 3] = lamp_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= PH_STARTUP;
      dir_q    <= '0;
      lights_q <= ALL_RED;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      lights_q <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_multiway_traffic_controller.sv
// ---------------------------------------------------------------------------
// tb_multiway_traffic_controller
//
// Directed bench for the N-way controller. One instance runs with a
// prescaler of 1 and covers sequencing, demand skipping and preemption;
// a second instance with TICK_DIV=4 covers the prescaler and async reset.
// Cycle numbering: cycle 0 is the period between reset release and the
// first rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_multiway_traffic_controller;

  localparam logic [11:0] ALLR = 12'b100_100_100_100;

  logic        clk;
  logic        rst;
  logic [3:0]  demand;
  logic        preempt_req;
  logic [1:0]  preempt_dir;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [2:0]  phase;
  logic        tick;

  logic        rst4;
  logic [3:0]  demand4;
  logic        preempt_req4;
  logic [1:0]  preempt_dir4;
  logic [11:0] lights4;
  logic [1:0]  active_dir4;
  logic [2:0]  phase4;
  logic        tick4;

  int n_cmp;
  int n_err;
  int cyc;

  multiway_traffic_controller #(
    .NUM_DIR(4), .TICK_DIV(1), .CNT_W(8), .STARTUP_TICKS(10),
    .GREEN_TICKS(30), .YELLOW_TICKS(5), .ALLRED_TICKS(2), .SKIP_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .demand(demand), .preempt_req(preempt_req),
    .preempt_dir(preempt_dir), .lights(lights), .active_dir(active_dir),
    .phase(phase), .tick(tick)
  );

  multiway_traffic_controller #(
    .NUM_DIR(4), .TICK_DIV(4), .CNT_W(8), .STARTUP_TICKS(10),
    .GREEN_TICKS(30), .YELLOW_TICKS(5), .ALLRED_TICKS(2), .SKIP_EN(1)
  ) dut4 (
    .clk(clk), .rst(rst4), .demand(demand4), .preempt_req(preempt_req4),
    .preempt_dir(preempt_dir4), .lights(lights4), .active_dir(active_dir4),
    .phase(phase4), .tick(tick4)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build the expected lamp word: every approach red except dir (if >= 0).
  function automatic logic [11:0] lamps(input int dir, input logic [2:0] code);
    logic [11:0] l;
    l = ALLR;
    for (int d = 0; d < 4; d++) begin
      if (d == dir) l[3*d +: 3] = code;
    end
    return l;
  endfunction

  function automatic int nonred(input logic [11:0] l);
    int n;
    n = 0;
    for (int d = 0; d < 4; d++) begin
      if (l[3*d +: 3] != 3'b100) n++;
    end
    return n;
  endfunction

  // Expected timeline for undisturbed running: startup 10, then per
  // approach 30 green + 5 yellow + 2 all-red = 37 cycles.
  task automatic expect_rr(input int c, input bit only2,
                           output logic [11:0] el, output logic [2:0] ep,
                           output logic [1:0] ea);
    int k;
    int off;
    int d;
    if (c < 10) begin
      el = ALLR; ep = 3'd0; ea = 2'd0;
    end else begin
      k   = (c - 10) / 37;
      off = (c - 10) % 37;
      d   = only2 ? ((k == 0) ? 0 : 2) : (k % 4);
      ea  = 2'(d);
      if (off < 30) begin
        el = lamps(d, 3'b001); ep = 3'd1;
      end else if (off < 35) begin
        el = lamps(d, 3'b010); ep = 3'd2;
      end else begin
        el = ALLR; ep = 3'd3;
      end
    end
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cyc = 0;
  endtask

  task automatic do_reset4();
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    cyc = 0;
  endtask

  // Outputs while reset is held low.
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (lights !== ALLR) begin n_err++; $display("[TB] FAIL reset_lights got=%b want=%b", lights, ALLR); end
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("[TB] FAIL reset_phase got=%0d want=0", phase); end
    n_cmp++; if (active_dir !== 2'd0) begin n_err++; $display("[TB] FAIL reset_dir got=%0d want=0", active_dir); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tick got=%b want=0", tick); end
    n_cmp++; if (lights4 !== ALLR) begin n_err++; $display("[TB] FAIL reset4_lights got=%b want=%b", lights4, ALLR); end
    n_cmp++; if (tick4 !== 1'b0) begin n_err++; $display("[TB] FAIL reset4_tick got=%b want=0", tick4); end
  endtask

  // Round-robin sequence under a fixed demand pattern.
  task automatic test_round_robin(input logic [3:0] dem, input bit only2, input int ncyc);
    logic [11:0] el;
    logic [2:0]  ep;
    logic [1:0]  ea;
    demand      = dem;
    preempt_req = 1'b0;
    preempt_dir = 2'd0;
    do_reset();
    while (cyc <= ncyc) begin
      expect_rr(cyc, only2, el, ep, ea);
      n_cmp++; if (lights !== el) begin n_err++; $display("[TB] FAIL rr_lights dem=%b cyc=%0d got=%b want=%b", dem, cyc, lights, el); end
      n_cmp++; if (phase !== ep) begin n_err++; $display("[TB] FAIL rr_phase dem=%b cyc=%0d got=%0d want=%0d", dem, cyc, phase, ep); end
      n_cmp++; if (active_dir !== ea) begin n_err++; $display("[TB] FAIL rr_dir dem=%b cyc=%0d got=%0d want=%0d", dem, cyc, active_dir, ea); end
      n_cmp++; if (tick !== 1'b1) begin n_err++; $display("[TB] FAIL rr_tick cyc=%0d got=%b want=1", cyc, tick); end
      step();
    end
  endtask

  // Preempt toward another approach during dir0 green; preempt_dir is
  // changed mid-preemption and must be ignored.
  task automatic test_preempt_other();
    logic [11:0] el;
    logic [2:0]  ep;
    logic [1:0]  ea;
    demand      = 4'b1111;
    preempt_req = 1'b0;
    preempt_dir = 2'd0;
    do_reset();
    while (cyc <= 75) begin
      if (cyc < 10)      begin el = ALLR;               ep = 3'd0; ea = 2'd0; end
      else if (cyc < 16) begin el = lamps(0, 3'b001);   ep = 3'd1; ea = 2'd0; end
      else if (cyc < 21) begin el = lamps(0, 3'b010);   ep = 3'd2; ea = 2'd0; end
      else if (cyc < 23) begin el = ALLR;               ep = 3'd3; ea = 2'd0; end
      else if (cyc < 61) begin el = lamps(2, 3'b001);   ep = 3'd4; ea = 2'd2; end
      else if (cyc < 66) begin el = lamps(2, 3'b010);   ep = 3'd2; ea = 2'd2; end
      else if (cyc < 68) begin el = ALLR;               ep = 3'd3; ea = 2'd2; end
      else               begin el = lamps(3, 3'b001);   ep = 3'd1; ea = 2'd3; end
      n_cmp++; if (lights !== el) begin n_err++; $display("[TB] FAIL pre_other_lights cyc=%0d got=%b want=%b", cyc, lights, el); end
      n_cmp++; if (phase !== ep) begin n_err++; $display("[TB] FAIL pre_other_phase cyc=%0d got=%0d want=%0d", cyc, phase, ep); end
      n_cmp++; if (active_dir !== ea) begin n_err++; $display("[TB] FAIL pre_other_dir cyc=%0d got=%0d want=%0d", cyc, active_dir, ea); end
      if (cyc == 15) begin preempt_req = 1'b1; preempt_dir = 2'd2; end
      if (cyc == 30) preempt_dir = 2'd1;
      if (cyc == 60) preempt_req = 1'b0;
      step();
    end
    preempt_dir = 2'd0;
  endtask

  // Preempt toward the approach that is already green.
  task automatic test_preempt_same();
    logic [11:0] el;
    logic [2:0]  ep;
    logic [1:0]  ea;
    demand      = 4'b1111;
    preempt_req = 1'b0;
    preempt_dir = 2'd0;
    do_reset();
    while (cyc <= 85) begin
      if (cyc < 10)      begin el = ALLR;               ep = 3'd0; ea = 2'd0; end
      else if (cyc < 21) begin el = lamps(0, 3'b001);   ep = 3'd1; ea = 2'd0; end
      else if (cyc < 71) begin el = lamps(0, 3'b001);   ep = 3'd4; ea = 2'd0; end
      else if (cyc < 76) begin el = lamps(0, 3'b010);   ep = 3'd2; ea = 2'd0; end
      else if (cyc < 78) begin el = ALLR;               ep = 3'd3; ea = 2'd0; end
      else               begin el = lamps(1, 3'b001);   ep = 3'd1; ea = 2'd1; end
      n_cmp++; if (lights !== el) begin n_err++; $display("[TB] FAIL pre_same_lights cyc=%0d got=%b want=%b", cyc, lights, el); end
      n_cmp++; if (phase !== ep) begin n_err++; $display("[TB] FAIL pre_same_phase cyc=%0d got=%0d want=%0d", cyc, phase, ep); end
      n_cmp++; if (active_dir !== ea) begin n_err++; $display("[TB] FAIL pre_same_dir cyc=%0d got=%0d want=%0d", cyc, active_dir, ea); end
      if (cyc == 20) begin preempt_req = 1'b1; preempt_dir = 2'd0; end
      if (cyc == 70) preempt_req = 1'b0;
      step();
    end
  endtask

  // Request withdrawn during the truncated yellow: normal rotation resumes.
  task automatic test_preempt_cancel();
    logic [11:0] el;
    logic [2:0]  ep;
    logic [1:0]  ea;
    demand      = 4'b1111;
    preempt_req = 1'b0;
    preempt_dir = 2'd0;
    do_reset();
    while (cyc <= 30) begin
      if (cyc < 10)      begin el = ALLR;               ep = 3'd0; ea = 2'd0; end
      else if (cyc < 16) begin el = lamps(0, 3'b001);   ep = 3'd1; ea = 2'd0; end
      else if (cyc < 21) begin el = lamps(0, 3'b010);   ep = 3'd2; ea = 2'd0; end
      else if (cyc < 23) begin el = ALLR;               ep = 3'd3; ea = 2'd0; end
      else               begin el = lamps(1, 3'b001);   ep = 3'd1; ea = 2'd1; end
      n_cmp++; if (lights !== el) begin n_err++; $display("[TB] FAIL pre_cancel_lights cyc=%0d got=%b want=%b", cyc, lights, el); end
      n_cmp++; if (phase !== ep) begin n_err++; $display("[TB] FAIL pre_cancel_phase cyc=%0d got=%0d want=%0d", cyc, phase, ep); end
      n_cmp++; if (active_dir !== ea) begin n_err++; $display("[TB] FAIL pre_cancel_dir cyc=%0d got=%0d want=%0d", cyc, active_dir, ea); end
      if (cyc == 15) begin preempt_req = 1'b1; preempt_dir = 2'd2; end
      if (cyc == 18) preempt_req = 1'b0;
      step();
    end
  endtask

  // TICK_DIV=4: tick every 4th cycle, startup 40 cycles, green 120 cycles.
  task automatic test_prescaler();
    logic [11:0] el;
    logic [2:0]  ep;
    do_reset4();
    while (cyc <= 165) begin
      if (cyc < 40)       begin el = ALLR;             ep = 3'd0; end
      else if (cyc < 160) begin el = lamps(0, 3'b001); ep = 3'd1; end
      else                begin el = lamps(0, 3'b010); ep = 3'd2; end
      n_cmp++; if (tick4 !== (cyc % 4 == 3)) begin n_err++; $display("[TB] FAIL div4_tick cyc=%0d got=%b want=%b", cyc, tick4, (cyc % 4 == 3)); end
      n_cmp++; if (lights4 !== el) begin n_err++; $display("[TB] FAIL div4_lights cyc=%0d got=%b want=%b", cyc, lights4, el); end
      n_cmp++; if (phase4 !== ep) begin n_err++; $display("[TB] FAIL div4_phase cyc=%0d got=%0d want=%0d", cyc, phase4, ep); end
      n_cmp++; if (nonred(lights4) > 1) begin n_err++; $display("[TB] FAIL div4_safety cyc=%0d nonred=%0d want<=1", cyc, nonred(lights4)); end
      step();
    end
  endtask

  // Async reset asserted mid-green takes effect without a clock edge,
  // then STARTUP restarts from scratch.
  task automatic test_async_reset();
    logic [11:0] el;
    logic [2:0]  ep;
    do_reset4();
    while (cyc < 100) step();
    n_cmp++; if (lights4 !== lamps(0, 3'b001)) begin n_err++; $display("[TB] FAIL areset_pre_lights got=%b want=%b", lights4, lamps(0, 3'b001)); end
    #2;
    rst4 = 1'b0;
    #1;
    n_cmp++; if (lights4 !== ALLR) begin n_err++; $display("[TB] FAIL areset_lights got=%b want=%b", lights4, ALLR); end
    n_cmp++; if (phase4 !== 3'd0) begin n_err++; $display("[TB] FAIL areset_phase got=%0d want=0", phase4); end
    n_cmp++; if (active_dir4 !== 2'd0) begin n_err++; $display("[TB] FAIL areset_dir got=%0d want=0", active_dir4); end
    n_cmp++; if (tick4 !== 1'b0) begin n_err++; $display("[TB] FAIL areset_tick got=%b want=0", tick4); end
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    cyc = 0;
    while (cyc <= 45) begin
      if (cyc < 40) begin el = ALLR;             ep = 3'd0; end
      else          begin el = lamps(0, 3'b001); ep = 3'd1; end
      n_cmp++; if (lights4 !== el) begin n_err++; $display("[TB] FAIL areset_restart_lights cyc=%0d got=%b want=%b", cyc, lights4, el); end
      n_cmp++; if (phase4 !== ep) begin n_err++; $display("[TB] FAIL areset_restart_phase cyc=%0d got=%0d want=%0d", cyc, phase4, ep); end
      step();
    end
  endtask

  // Test sequence.
  initial begin
    n_cmp        = 0;
    n_err        = 0;
    cyc          = 0;
    rst          = 1'b0;
    demand       = 4'b1111;
    preempt_req  = 1'b0;
    preempt_dir  = 2'd0;
    rst4         = 1'b0;
    demand4      = 4'b1111;
    preempt_req4 = 1'b0;
    preempt_dir4 = 2'd0;

    $display("[TB] starting");
    test_reset();
    test_round_robin(4'b1111, 1'b0, 60);
    test_round_robin(4'b0100, 1'b1, 125);
    test_round_robin(4'b0000, 1'b0, 190);
    test_preempt_other();
    test_preempt_same();
    test_preempt_cancel();
    test_prescaler();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
